alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- 8-bit, 16-function arithmetic/logic unit with a 16-bit registered result and an output enable.
- Sits in the datapath as a single-cycle-latency execution unit.
- Operands and opcode are sampled on the rising clock edge; the result appears on y one cycle later.

Parameters:
- DW, 8, operand width (result width is 2*DW).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  DW  operand A.
- b  in  DW  operand B.
- command  in  4  opcode.
- enable  in  1  operation/output enable.
- y  out  2*DW  result.

Behaviour:
- Reset: while rst_n=0, the result register and the registered enable clear to 0 immediately, without a clock edge. y=16'h0000, or high-Z when ALU_TRISTATE_EN is defined.
- Latency: on each rising clk with enable=1, the result of (a, b, command) is loaded into the result register. y shows it after one cycle.
- enable=0 at an edge: the result register holds its value and the registered enable clears. Output gating follows the registered enable, so it too takes effect one cycle later.
- Opcodes. Results are zero-extended to 16 bits unless stated otherwise:
  - 0000 ADD: a+b; bit 8 is the carry.
  - 0001 INC: a+1; 8'hFF gives 16'h0100.
  - 0010 SUB: a-b computed in 16-bit two's complement (3-5 = 16'hFFFE).
  - 0011 DEC: a-1 in 16 bits (0 gives 16'hFFFF).
  - 0100 MUL: a*b, full 16-bit unsigned product.
  - 0101 DIV: unsigned a/b. Quotient in y[7:0], remainder in y[15:8]. If b=0, y=16'hFFFF.
  - 0110 SHR: a>>1, logical; zero fills the MSB.
  - 0111 SHL: a<<1 into 9 bits; the shifted-out bit lands in y[8].
  - 1000 AND: a&b.
  - 1001 OR: a|b.
  - 1010 INV: ~a; y[15:8]=0.
  - 1011 NAND: ~(a&b).
  - 1100 NOR: ~(a|b).
  - 1101 XOR: a^b.
  - 1110 XNOR: ~(a^b).
  - 1111 BUF: a.
- All 16 codes are defined; there is no illegal opcode.
- Operand changes between edges do not affect y.
- Reset asserted mid-operation clears y immediately. The first valid result appears one edge after rst_n deassertion with enable=1.

Optional Feature:
- Macro: ALU_TRISTATE_EN.
- Defined: y = registered-enable ? result register : 16'hzzzz. This supports a shared bus.
- Undefined: y = registered-enable ? result register : 16'h0000. There are no tri-state drivers.

Decomposition:
- Package alu_pkg: 4-bit opcode enum/localparams (ADD…BUF, values above), DW default, and DIV_BY_ZERO constant 16'hFFFF.
- One sub-module, alu_div8: combinational restoring divider producing quotient and remainder with a divide-by-zero flag.
- Everything else lives in alu_core: operation case plus result/enable registers.

Test Plan:
- Reset: rst_n=0 mid-stream with enable=1 -> y=0 (or Z with the macro) immediately, with no clk edge; it stays so until the first enabled edge after release.
- Arithmetic sweep: a=20, b=10, enable=1.
  - ADD -> 16'd30
  - SUB -> 16'd10
  - MUL -> 16'd200
  - DIV -> 16'h0002 (q=2, r=0)
  - INC -> 21
  - DEC -> 19
  - Each value appears one cycle after the edge.
- Boundaries:
  - a=255, b=1 ADD -> 16'h0100.
  - a=0 DEC -> 16'hFFFF.
  - a=3, b=5 SUB -> 16'hFFFE.
  - a=255, b=255 MUL -> 16'hFE01.
  - a=7, b=0 DIV -> 16'hFFFF.
  - a=17, b=5 DIV -> 16'h0203.
- Logic/shift with a=8'hA5, b=8'h0F:
  - AND -> 16'h0005
  - OR -> 16'h00AF
  - XOR -> 16'h00AA
  - XNOR -> 16'h0055
  - NAND -> 16'h00FA
  - NOR -> 16'h0050
  - INV -> 16'h005A
  - BUF -> 16'h00A5
  - SHR -> 16'h0052
  - SHL -> 16'h014A
- Enable: a=20, b=10, ADD with enable=0 -> y=0 (or Z) one cycle later. Then enable=1, a=25, b=17, ADD -> y=16'd42 one cycle later.
- Exhaustive: a,b in 0..15, all 16 opcodes, enable=1 -> every result matches a reference model, checked one cycle after each edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_core slice: opcode encoding, default
// operand width and the divide-by-zero result pattern.
package alu_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  localparam logic [15:0] DIV_BY_ZERO = 16'hFFFF;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_INC  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_DEC  = 4'b0011,
    OP_MUL  = 4'b0100,
    OP_DIV  = 4'b0101,
    OP_SHR  = 4'b0110,
    OP_SHL  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_INV  = 4'b1010,
    OP_NAND = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_XOR  = 4'b1101,
    OP_XNOR = 4'b1110,
    OP_BUF  = 4'b1111
  } opcode_t;

endpackage

// File: rtl/alu_div8.sv
// Combinational restoring divider: unsigned quotient and remainder of
// dividend/divisor, plus a flag for a zero divisor (quotient/remainder are
// then don't-care and the caller substitutes its own pattern).
module alu_div8
  import alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  logic [DW-1:0] part_rem;
  logic [DW:0]   trial;

  // One restoring step per dividend bit, MSB first.
  always_comb begin
    part_rem = '0;
    trial    = '0;
    quotient = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      trial = {part_rem, dividend[DW-1-i]};
      if (trial >= {1'b0, divisor}) begin
        trial = trial - {1'b0, divisor};
        quotient[DW-1-i] = 1'b1;
      end
      part_rem = trial[DW-1:0];
    end
    remainder = part_rem;
  end

  // Zero divisor detection.
  always_comb begin
    div_by_zero = (divisor == '0);
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: 16-function ALU with a registered 2*DW result and a registered
// output enable. Optional macro ALU_TRISTATE_EN: when defined, y floats
// (high-Z) while the registered enable is low; otherwise y is driven to 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    command,
  input  logic          enable,
  output logic [2*DW-1:0] y
);

  localparam logic [2*DW-1:0] ONE = (2*DW)'(1);

  opcode_t         op;
  logic [2*DW-1:0] ext_a;
  logic [2*DW-1:0] ext_b;
  logic [2*DW-1:0] next_result;
  logic [2*DW-1:0] result_q;
  logic            en_q;
  logic [DW-1:0]   div_quo;
  logic [DW-1:0]   div_rem;
  logic            div_zero;

  assign op    = opcode_t'(command);
  assign ext_a = {{DW{1'b0}}, a};
  assign ext_b = {{DW{1'b0}}, b};

  alu_div8 #(
    .DW (DW)
  ) u_div (
    .dividend    (a),
    .divisor     (b),
    .quotient    (div_quo),
    .remainder   (div_rem),
    .div_by_zero (div_zero)
  );

  // Operation select; all arithmetic is done at 2*DW so carries, borrows
  // and products land in the upper half naturally.
  always_comb begin
    next_result = '0;
    case (op)
      OP_ADD:  next_result = ext_a + ext_b;
      OP_INC:  next_result = ext_a + ONE;
      OP_SUB:  next_result = ext_a - ext_b;
      OP_DEC:  next_result = ext_a - ONE;
      OP_MUL:  next_result = ext_a * ext_b;
      OP_DIV:  next_result = div_zero ? (2*DW)'(DIV_BY_ZERO) : {div_rem, div_quo};
      OP_SHR:  next_result = ext_a >> 1;
      OP_SHL:  next_result = ext_a << 1;
      OP_AND:  next_result = {{DW{1'b0}}, a & b};
      OP_OR:   next_result = {{DW{1'b0}}, a | b};
      OP_INV:  next_result = {{DW{1'b0}}, ~a};
      OP_NAND: next_result = {{DW{1'b0}}, ~(a & b)};
      OP_NOR:  next_result = {{DW{1'b0}}, ~(a | b)};
      OP_XOR:  next_result = {{DW{1'b0}}, a ^ b};
      OP_XNOR: next_result = {{DW{1'b0}}, ~(a ^ b)};
      OP_BUF:  next_result = ext_a;
      default: next_result = '0;
    endcase
  end

  // Result register loads only when enabled; enable is always registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      en_q     <= 1'b0;
    end else begin
      en_q <= enable;
      if (enable) begin
        result_q <= next_result;
      end
    end
  end

`ifdef ALU_TRISTATE_EN
  assign y = en_q ? result_q : 'z;
`else
  assign y = en_q ? result_q : '0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: the driver pushes the expected y for every
// edge it drives; a monitor pops and compares shortly after each rising edge.
module tb_alu_core;
  import alu_pkg::*;

`ifdef ALU_TRISTATE_EN
  localparam logic [15:0] IDLE = 16'hzzzz;
`else
  localparam logic [15:0] IDLE = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  command;
  logic        enable;
  logic [15:0] y;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  c;
    logic [15:0] e;
  } vec_t;

  vec_t dir[$];

  alu_core #(.DW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .command (command),
    .enable  (enable),
    .y       (y)
  );

  always #5 clk = ~clk;

  // Independent reference for the exhaustive sweep.
  function automatic logic [15:0] ref_model(input int ra, input int rb, input int rc);
    int r;
    case (rc)
      0:  r = ra + rb;
      1:  r = ra + 1;
      2:  r = ra - rb;
      3:  r = ra - 1;
      4:  r = ra * rb;
      5:  r = (rb == 0) ? 32'hFFFF : (((ra % rb) << 8) | (ra / rb));
      6:  r = ra / 2;
      7:  r = ra * 2;
      8:  r = ra & rb;
      9:  r = ra | rb;
      10: r = 255 - ra;
      11: r = 255 - (ra & rb);
      12: r = 255 - (ra | rb);
      13: r = ra ^ rb;
      14: r = 255 - (ra ^ rb);
      default: r = ra;
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    vectors++;
    if (y !== exp) begin
      miscompares++;
      $display("FAIL %s: y=%h expected=%h", name, y, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tc,
                       input logic te, input logic [15:0] texp);
    @(negedge clk);
    a = ta; b = tb; command = tc; enable = te;
    exp_q.push_back(texp);
  endtask

  function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb,
                              input opcode_t vc, input logic [15:0] ve);
    vec_t v;
    v.a = va; v.b = vb; v.c = vc; v.e = ve;
    return v;
  endfunction

  // Monitor: one expected value per driven edge, checked 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (y !== e) begin
        miscompares++;
        $display("FAIL vec a=%h b=%h cmd=%h: y=%h expected=%h", a, b, command, y, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; command = '0; enable = 1'b0;
    #1;
    check("reset_state", IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic sweep a=20 b=10
    dir.push_back(mk(8'd20, 8'd10, OP_ADD, 16'd30));
    dir.push_back(mk(8'd20, 8'd10, OP_SUB, 16'd10));
    dir.push_back(mk(8'd20, 8'd10, OP_MUL, 16'd200));
    dir.push_back(mk(8'd20, 8'd10, OP_DIV, 16'h0002));
    dir.push_back(mk(8'd20, 8'd10, OP_INC, 16'd21));
    dir.push_back(mk(8'd20, 8'd10, OP_DEC, 16'd19));
    // Boundaries
    dir.push_back(mk(8'd255, 8'd1,   OP_ADD, 16'h0100));
    dir.push_back(mk(8'd255, 8'd0,   OP_INC, 16'h0100));
    dir.push_back(mk(8'd0,   8'd0,   OP_DEC, 16'hFFFF));
    dir.push_back(mk(8'd3,   8'd5,   OP_SUB, 16'hFFFE));
    dir.push_back(mk(8'd255, 8'd255, OP_MUL, 16'hFE01));
    dir.push_back(mk(8'd7,   8'd0,   OP_DIV, 16'hFFFF));
    dir.push_back(mk(8'd17,  8'd5,   OP_DIV, 16'h0203));
    // Logic / shift
    dir.push_back(mk(8'hA5, 8'h0F, OP_AND,  16'h0005));
    dir.push_back(mk(8'hA5, 8'h0F, OP_OR,   16'h00AF));
    dir.push_back(mk(8'hA5, 8'h0F, OP_XOR,  16'h00AA));
    dir.push_back(mk(8'hA5, 8'h0F, OP_XNOR, 16'h0055));
    dir.push_back(mk(8'hA5, 8'h0F, OP_NAND, 16'h00FA));
    dir.push_back(mk(8'hA5, 8'h0F, OP_NOR,  16'h0050));
    dir.push_back(mk(8'hA5, 8'h0F, OP_INV,  16'h005A));
    dir.push_back(mk(8'hA5, 8'h0F, OP_BUF,  16'h00A5));
    dir.push_back(mk(8'hA5, 8'h0F, OP_SHR,  16'h0052));
    dir.push_back(mk(8'hA5, 8'h0F, OP_SHL,  16'h014A));

    foreach (dir[i]) drive(dir[i].a, dir[i].b, dir[i].c, 1'b1, dir[i].e);

    // Enable gating, then re-enable
    drive(8'd20, 8'd10, OP_ADD, 1'b0, IDLE);
    drive(8'd25, 8'd17, OP_ADD, 1'b1, 16'd42);
    @(posedge clk);
    #3;
    a = 8'd99; b = 8'd1;
    #1;
    check("operand_change_between_edges", 16'd42);

    // Asynchronous reset mid-stream with enable held high
    drive(8'd20, 8'd10, OP_ADD, 1'b1, 16'd30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", IDLE);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release_before_edge", IDLE);
    drive(8'd20, 8'd10, OP_ADD, 1'b1, 16'd30);

    // Exhaustive small-operand sweep
    for (int c = 0; c < 16; c++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          drive(ia[7:0], ib[7:0], c[3:0], 1'b1, ref_model(ia, ib, c));

    // Bounded drain of the scoreboard
    repeat (4) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d pending expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
